mul_issue_arbiter: RTL and testbench
====================================

Name: mul_issue_arbiter

Overview:
- Shares one fixed-latency pipelined integer multiplier (MUL/MULH/MULHSU/MULHU/MULW) between two requesters, e.g. the integer issue slot and the vector/microcode sequencer.
- Round-robin arbitration, valid/ready request ports, and an in-flight delay line that carries owner and tag alongside the multiplier pipeline.
- Returns each result to its owner exactly LATENCY cycles after issue, and squashes in-flight operations on a per-requester kill.
- The multiplier has no valid-out and no backpressure; this block is its only sequencer.

Parameters:
- XLEN, 64, operand/result width.
- TAG_W, 5, requester-supplied tag width, returned untouched.
- LATENCY, 3, cycles from the mul_req_valid cycle to the cycle mul_resp_data carries that result. Must be ≥1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid_0/1  in  1  requester i has an operation.
- req_ready_0/1  out  1  operation i is accepted this cycle.
- req_fn_0/1  in  4  mul fn; [1:0]: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- req_dw_0/1  in  1  1=64-bit, 0=32-bit (W) result.
- req_in1_0/1, req_in2_0/1  in  XLEN  operands.
- req_tag_0/1  in  TAG_W  opaque tag.
- kill_0/1  in  1  squash all in-flight and presented ops of requester i.
- resp_valid_0/1  out  1  result for requester i this cycle.
- resp_tag  out  TAG_W  tag of the returning op.
- resp_data  out  XLEN  equals mul_resp_data.
- mul_req_valid  out  1  to multiplier.
- mul_req_fn  out  4  to multiplier.
- mul_req_dw  out  1  to multiplier.
- mul_req_in1, mul_req_in2  out  XLEN  to multiplier.
- mul_resp_data  in  XLEN  from multiplier.
- busy  out  1  any delay-line entry valid, or mul_req_valid.

Behaviour:
- Eligibility: eligible_i = req_valid_i & ~kill_i & ~reset.
- Arbitration is combinational in the issue cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester named by pointer rr (1 bit) is granted.
  - At most one grant per cycle.
- Handshake:
  - req_ready_i = grant_i.
  - mul_req_valid = grant_0 | grant_1.
  - mul_req_fn, dw, in1 and in2 are muxed from the granted requester; they are don't-care when mul_req_valid=0.
  - The multiplier accepts every cycle, so there are no issue stalls.
  - Requester inputs must remain stable while valid and not ready.
- Pointer update: on any grant, rr <= ~granted_id, registered. With no grant, rr holds. Both requesters valid every cycle therefore alternate 0,1,0,1 starting from rr.
- Delay line: LATENCY stages of {v, owner, tag}.
  - Stage 0 loads {mul_req_valid, granted_id, granted tag} at each clock edge; stage k loads stage k-1.
  - The entry leaving the last register is presented in cycle T+LATENCY for an issue in cycle T.
  - With LATENCY=1 the single stage is the output stage.
- Response outputs:
  - resp_valid_i = out.v & (out.owner==i) & ~kill_i.
  - resp_tag = out.tag.
  - resp_data = mul_resp_data, combinational pass-through.
  - Responses have no ready; owners must sink them.
- Kill, in the cycle kill_i is high:
  - Every delay-line entry with owner i (including the output stage) has v cleared at the next edge.
  - resp_valid_i is forced 0.
  - req_i is not granted.
  - The other requester is unaffected and may be granted, and its in-flight entries proceed.
  - The multiplier still computes squashed ops; only their valid is dropped.
  - Kills of both requesters in the same cycle clear everything.
- Simultaneous events:
  - An issue and a response for the same requester in the same cycle is legal.
  - A kill and a new req from the same requester: kill wins; there is no grant.
- Reset values, at the edge with reset high:
  - rr=0.
  - All delay-line v=0.
  - req_ready_*, mul_req_valid, resp_valid_* and busy are 0 while reset is high.
  - Reset mid-operation discards all in-flight results; no response is emitted afterwards for pre-reset ops.
- Widths: there is no arithmetic in this block. Tag, data and fn pass through unmodified. The W sign-extension is done inside the multiplier.
- Throughput: one issue per cycle across both requesters. Up to LATENCY ops are in flight.

Test Plan:
- After reset: req_valid_0=1, fn=0, dw=1, in1=3, in2=5, tag=7 at cycle T -> req_ready_0=1 at T; mul_req_valid=1 at T; resp_valid_0=1, resp_tag=7, resp_data=15 at T+3; resp_valid_1=0 throughout.
- Both requesters valid continuously for 6 cycles after reset (tags 0..5 each) -> grants alternate 0,1,0,1,0,1; responses return in the same order, each 3 cycles after its grant, with matching owner and tag.
- MULHU with in1=in2=0xFFFF_FFFF_FFFF_FFFF from requester 1 -> resp_data=0xFFFF_FFFF_FFFF_FFFE on resp_valid_1. MULW (fn=0, dw=0) with in1=0x7FFF_FFFF, in2=2 -> resp_data=0xFFFF_FFFF_FFFF_FFFE.
- Issue req0 tags 1,2 and req1 tag 3 on consecutive cycles, then kill_0 for one cycle before any returns -> only resp_valid_1 with tag 3 appears; busy falls to 0 after the last entry drains.
- kill_1 asserted while req_valid_1=1 and req_valid_0=1 with rr=1 -> req0 granted that cycle, req_ready_1=0; rr becomes 1.
- Assert reset for one cycle with 3 ops in flight -> no resp_valid in the following 4 cycles; busy=0; the first post-reset simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/mul_issue_arbiter_if.sv
// Requester, response and multiplier-side signals of mul_issue_arbiter.
// slave: the arbiter's view; master: the environment's view.
interface mul_issue_arbiter_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  logic             req_valid_0;
  logic             req_valid_1;
  logic             req_ready_0;
  logic             req_ready_1;
  logic [3:0]       req_fn_0;
  logic [3:0]       req_fn_1;
  logic             req_dw_0;
  logic             req_dw_1;
  logic [XLEN-1:0]  req_in1_0;
  logic [XLEN-1:0]  req_in1_1;
  logic [XLEN-1:0]  req_in2_0;
  logic [XLEN-1:0]  req_in2_1;
  logic [TAG_W-1:0] req_tag_0;
  logic [TAG_W-1:0] req_tag_1;
  logic             kill_0;
  logic             kill_1;
  logic             resp_valid_0;
  logic             resp_valid_1;
  logic [TAG_W-1:0] resp_tag;
  logic [XLEN-1:0]  resp_data;
  logic             mul_req_valid;
  logic [3:0]       mul_req_fn;
  logic             mul_req_dw;
  logic [XLEN-1:0]  mul_req_in1;
  logic [XLEN-1:0]  mul_req_in2;
  logic [XLEN-1:0]  mul_resp_data;
  logic             busy;

  modport slave (
    input  req_valid_0, req_valid_1, req_fn_0, req_fn_1, req_dw_0, req_dw_1,
    input  req_in1_0, req_in1_1, req_in2_0, req_in2_1, req_tag_0, req_tag_1,
    input  kill_0, kill_1, mul_resp_data,
    output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_tag,
    output resp_data, mul_req_valid, mul_req_fn, mul_req_dw, mul_req_in1,
    output mul_req_in2, busy
  );

  modport master (
    output req_valid_0, req_valid_1, req_fn_0, req_fn_1, req_dw_0, req_dw_1,
    output req_in1_0, req_in1_1, req_in2_0, req_in2_1, req_tag_0, req_tag_1,
    output kill_0, kill_1, mul_resp_data,
    input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_tag,
    input  resp_data, mul_req_valid, mul_req_fn, mul_req_dw, mul_req_in1,
    input  mul_req_in2, busy
  );
endinterface

// File: rtl/mul_issue_arbiter.sv
// Round-robin sequencer sharing one fixed-latency pipelined multiplier
// between two requesters. A delay line of {valid, owner, tag} runs beside
// the multiplier pipe so each result returns to its owner LATENCY cycles
// after issue; per-requester kill squashes that owner's in-flight ops.
// LATENCY must be at least 1.
module mul_issue_arbiter #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned LATENCY = 3
) (
  input logic              clock,
  input logic              reset,
  mul_issue_arbiter_if.slave bus
);

  typedef struct packed {
    logic             v;
    logic             owner;
    logic [TAG_W-1:0] tag;
  } dl_entry_t;

  dl_entry_t        dl [LATENCY];
  logic             rr;
  logic             elig_0, elig_1;
  logic             grant_0, grant_1;
  logic             issue;
  logic             granted_id;
  logic [1:0]       kill_vec;
  logic [TAG_W-1:0] granted_tag;
  logic [XLEN-1:0]  sel_in1, sel_in2;
  logic [3:0]       sel_fn;
  logic             sel_dw;
  logic             any_inflight;
  dl_entry_t        out_e;

  // Eligibility and round-robin grant, decided combinationally in the issue cycle
  always_comb begin
    elig_0     = bus.req_valid_0 & ~bus.kill_0 & ~reset;
    elig_1     = bus.req_valid_1 & ~bus.kill_1 & ~reset;
    grant_0    = elig_0 & (~elig_1 | ~rr);
    grant_1    = elig_1 & (~elig_0 | rr);
    issue      = grant_0 | grant_1;
    granted_id = grant_1;
    kill_vec   = {bus.kill_1, bus.kill_0};
  end

  // Operand/tag mux from the granted requester
  always_comb begin
    sel_fn      = bus.req_fn_0;
    sel_dw      = bus.req_dw_0;
    sel_in1     = bus.req_in1_0;
    sel_in2     = bus.req_in2_0;
    granted_tag = bus.req_tag_0;
    if (granted_id) begin
      sel_fn      = bus.req_fn_1;
      sel_dw      = bus.req_dw_1;
      sel_in1     = bus.req_in1_1;
      sel_in2     = bus.req_in2_1;
      granted_tag = bus.req_tag_1;
    end
  end

  // Round-robin pointer and in-flight delay line; a kill drops the valid of
  // that owner's entries as they advance, the output stage simply retires
  always_ff @(posedge clock) begin
    if (reset) begin
      rr <= 1'b0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        dl[k].v <= 1'b0;
      end
    end else begin
      if (issue) begin
        rr <= ~granted_id;
      end
      dl[0].v     <= issue;
      dl[0].owner <= granted_id;
      dl[0].tag   <= granted_tag;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        dl[k].v     <= dl[k-1].v & ~kill_vec[dl[k-1].owner];
        dl[k].owner <= dl[k-1].owner;
        dl[k].tag   <= dl[k-1].tag;
      end
    end
  end

  // Response steering and busy indication
  always_comb begin
    out_e        = dl[LATENCY-1];
    any_inflight = 1'b0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      any_inflight = any_inflight | dl[k].v;
    end
  end

  assign bus.req_ready_0   = grant_0;
  assign bus.req_ready_1   = grant_1;
  assign bus.mul_req_valid = issue;
  assign bus.mul_req_fn    = sel_fn;
  assign bus.mul_req_dw    = sel_dw;
  assign bus.mul_req_in1   = sel_in1;
  assign bus.mul_req_in2   = sel_in2;
  assign bus.resp_valid_0  = out_e.v & ~out_e.owner & ~bus.kill_0 & ~reset;
  assign bus.resp_valid_1  = out_e.v &  out_e.owner & ~bus.kill_1 & ~reset;
  assign bus.resp_tag      = out_e.tag;
  assign bus.resp_data     = bus.mul_resp_data;
  assign bus.busy          = (any_inflight | issue) & ~reset;

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Bench for mul_issue_arbiter: pipelined multiplier model, timestamp-queue
// reference model checked every cycle, a vector table, directed sequences
// and a randomized phase.
module tb_mul_issue_arbiter;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned LAT   = 3;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mul_issue_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mul_issue_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] mul_ref(input logic [3:0] fn, input logic dw,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ua, ub, sa, sb, p;
    logic [63:0]  r;
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    case (fn[1:0])
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    r = (fn[1:0] == 2'd0) ? p[63:0] : p[127:64];
    if (!dw) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Multiplier model: fixed latency, no valid, no stall
  logic [63:0] mpipe [LAT];
  always @(posedge clock) begin
    mpipe[0] <= mul_ref(bus.mul_req_fn, bus.mul_req_dw, bus.mul_req_in1, bus.mul_req_in2);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_resp_data = mpipe[LAT-1];

  // Reference model: list of outstanding ops stamped with their due cycle
  typedef struct {
    bit          owner;
    logic [4:0]  tag;
    int          due;
    logic [63:0] data;
  } rec_t;

  rec_t q[$];
  rec_t nq[$];
  rec_t hr;
  rec_t nr;
  bit   m_rr = 0;
  int   ncyc = 0;
  bit   m_g0 = 0, m_g1 = 0;
  bit   e0, e1, g0, g1, hit, busy_e, rv0, rv1;

  always @(negedge clock) begin
    e0 = bus.req_valid_0 && !bus.kill_0 && !reset;
    e1 = bus.req_valid_1 && !bus.kill_1 && !reset;
    if (e0 && e1) begin
      g0 = !m_rr;
      g1 = m_rr;
    end else begin
      g0 = e0;
      g1 = e1;
    end
    hit    = 0;
    busy_e = g0 || g1;
    foreach (q[i]) begin
      if (q[i].due == ncyc) begin
        hit = 1;
        hr  = q[i];
      end
      if (q[i].due >= ncyc) busy_e = 1;
    end
    if (reset) busy_e = 0;
    rv0 = hit && !hr.owner && !bus.kill_0 && !reset;
    rv1 = hit &&  hr.owner && !bus.kill_1 && !reset;
    chk("m_ready_0", 64'(bus.req_ready_0), 64'(g0));
    chk("m_ready_1", 64'(bus.req_ready_1), 64'(g1));
    chk("m_mul_valid", 64'(bus.mul_req_valid), 64'(g0 || g1));
    chk("m_resp_valid_0", 64'(bus.resp_valid_0), 64'(rv0));
    chk("m_resp_valid_1", 64'(bus.resp_valid_1), 64'(rv1));
    chk("m_busy", 64'(bus.busy), 64'(busy_e));
    if (rv0 || rv1) begin
      chk("m_resp_tag", 64'(bus.resp_tag), 64'(hr.tag));
      chk("m_resp_data", bus.resp_data, hr.data);
    end
    if (g0 || g1) begin
      chk("m_mul_in1", bus.mul_req_in1, g1 ? bus.req_in1_1 : bus.req_in1_0);
      chk("m_mul_in2", bus.mul_req_in2, g1 ? bus.req_in2_1 : bus.req_in2_0);
      chk("m_mul_fn",  64'(bus.mul_req_fn), 64'(g1 ? bus.req_fn_1 : bus.req_fn_0));
      chk("m_mul_dw",  64'(bus.mul_req_dw), 64'(g1 ? bus.req_dw_1 : bus.req_dw_0));
    end
    if (reset) begin
      q.delete();
      m_rr = 0;
    end else begin
      nq.delete();
      foreach (q[i]) begin
        if (q[i].due > ncyc && !(q[i].owner ? bus.kill_1 : bus.kill_0)) nq.push_back(q[i]);
      end
      q = nq;
      if (g0 || g1) begin
        nr.owner = g1;
        nr.tag   = g1 ? bus.req_tag_1 : bus.req_tag_0;
        nr.due   = ncyc + LAT;
        nr.data  = g1 ? mul_ref(bus.req_fn_1, bus.req_dw_1, bus.req_in1_1, bus.req_in2_1)
                      : mul_ref(bus.req_fn_0, bus.req_dw_0, bus.req_in1_0, bus.req_in2_0);
        q.push_back(nr);
        m_rr = g0;
      end
    end
    m_g0 = g0;
    m_g1 = g1;
    ncyc++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic at_mid;
    @(negedge clock);
    #1;
  endtask

  task automatic idle;
    bus.req_valid_0 = 0; bus.req_valid_1 = 0;
    bus.kill_0 = 0;      bus.kill_1 = 0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] fn, input logic dw,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    if (i == 0) begin
      bus.req_valid_0 = v; bus.req_fn_0 = fn; bus.req_dw_0 = dw;
      bus.req_in1_0 = a;   bus.req_in2_0 = b; bus.req_tag_0 = tag;
    end else begin
      bus.req_valid_1 = v; bus.req_fn_1 = fn; bus.req_dw_1 = dw;
      bus.req_in1_1 = a;   bus.req_in2_1 = b; bus.req_tag_1 = tag;
    end
  endtask

  task automatic reset_pulse;
    idle;
    reset = 1;
    tick;
    reset = 0;
  endtask

  // Single op from requester i, expect its result exactly LAT cycles later
  task automatic single(input int i, input logic [3:0] fn, input logic dw, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp,
                        input string nm);
    idle;
    set_req(i, 1, fn, dw, a, b, tag);
    at_mid;
    chk({nm, "_ready"}, 64'(i != 0 ? bus.req_ready_1 : bus.req_ready_0), 64'd1);
    chk({nm, "_mul_valid"}, 64'(bus.mul_req_valid), 64'd1);
    tick;
    idle;
    repeat (LAT - 1) begin
      at_mid;
      chk({nm, "_early"}, 64'(bus.resp_valid_0 | bus.resp_valid_1), 64'd0);
      tick;
    end
    at_mid;
    chk({nm, "_rv_own"}, 64'(i != 0 ? bus.resp_valid_1 : bus.resp_valid_0), 64'd1);
    chk({nm, "_rv_other"}, 64'(i != 0 ? bus.resp_valid_0 : bus.resp_valid_1), 64'd0);
    chk({nm, "_tag"}, 64'(bus.resp_tag), 64'(tag));
    chk({nm, "_data"}, bus.resp_data, exp);
    tick;
  endtask

  typedef struct {
    logic v0, v1, k0, k1, r0, r1;
  } vec_t;

  vec_t tbl [12];
  int   n0, n1, k, rk, cnt0, cnt1;
  bit   new0, new1;

  initial begin
    tbl[0]  = '{H, H, L, L, H, L};
    tbl[1]  = '{H, H, L, L, L, H};
    tbl[2]  = '{H, L, L, L, H, L};
    tbl[3]  = '{H, H, H, L, L, H};
    tbl[4]  = '{L, H, L, L, L, H};
    tbl[5]  = '{H, H, L, L, H, L};
    tbl[6]  = '{H, H, L, H, H, L};
    tbl[7]  = '{H, H, L, L, L, H};
    tbl[8]  = '{L, L, L, L, L, L};
    tbl[9]  = '{H, H, H, H, L, L};
    tbl[10] = '{H, H, L, L, H, L};
    tbl[11] = '{H, H, L, L, L, H};

    idle;
    set_req(0, 0, 4'd0, 1'b1, 64'd0, 64'd0, 5'd0);
    set_req(1, 0, 4'd0, 1'b1, 64'd0, 64'd0, 5'd0);
    reset = 1;
    at_mid;
    chk("rst_ready_0", 64'(bus.req_ready_0), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    repeat (3) tick;
    reset = 0;

    // Basic MUL, then MULHU and MULW
    single(0, 4'd0, 1'b1, 64'd3, 64'd5, 5'd7, 64'd15, "A_mul");
    single(1, 4'd3, 1'b1, '1, '1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, "C_mulhu");
    single(0, 4'd0, 1'b0, 64'h7FFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, "C_mulw");

    // Both requesters streaming: alternate grants, in-order returns
    reset_pulse;
    n0 = 0; n1 = 0; k = 0; rk = 0;
    for (int t = 0; t < 12; t++) begin
      set_req(0, n0 < 3, 4'd0, 1'b1, 64'(2 * n0), 64'd3, 5'(2 * n0));
      set_req(1, n1 < 3, 4'd0, 1'b1, 64'(2 * n1 + 1), 64'd3, 5'(2 * n1 + 1));
      at_mid;
      if (bus.req_ready_0 || bus.req_ready_1) begin
        chk("B_grant_owner", 64'(bus.req_ready_1), 64'(k % 2));
        chk("B_grant_cycle", 64'(t), 64'(k));
        if (bus.req_ready_0) n0++; else n1++;
        k++;
      end
      if (bus.resp_valid_0 || bus.resp_valid_1) begin
        chk("B_resp_owner", 64'(bus.resp_valid_1), 64'(rk % 2));
        chk("B_resp_tag", 64'(bus.resp_tag), 64'(rk));
        chk("B_resp_cycle", 64'(t), 64'(rk + 3));
        rk++;
      end
      tick;
    end
    chk("B_grants", 64'(k), 64'd6);
    chk("B_resps", 64'(rk), 64'd6);

    // Kill requester 0 after issuing two of its ops and one of requester 1
    reset_pulse;
    set_req(0, 1, 4'd0, 1'b1, 64'd2, 64'd2, 5'd1);
    tick;
    set_req(0, 1, 4'd0, 1'b1, 64'd3, 64'd3, 5'd2);
    tick;
    idle;
    set_req(1, 1, 4'd0, 1'b1, 64'd4, 64'd4, 5'd3);
    bus.kill_0 = 1;
    at_mid;
    chk("D_ready_1", 64'(bus.req_ready_1), 64'd1);
    tick;
    idle;
    cnt0 = 0; cnt1 = 0;
    for (int j = 3; j < 9; j++) begin
      at_mid;
      if (bus.resp_valid_0) cnt0++;
      if (bus.resp_valid_1) begin
        cnt1++;
        chk("D_tag", 64'(bus.resp_tag), 64'd3);
        chk("D_data", bus.resp_data, 64'd16);
        chk("D_cycle", 64'(j), 64'd5);
      end
      if (j == 5) chk("D_busy_last", 64'(bus.busy), 64'd1);
      if (j >= 6) chk("D_busy_drained", 64'(bus.busy), 64'd0);
      tick;
    end
    chk("D_resp0_count", 64'(cnt0), 64'd0);
    chk("D_resp1_count", 64'(cnt1), 64'd1);

    // Kill of requester 1 while rr points at it
    reset_pulse;
    set_req(0, 1, 4'd0, 1'b1, 64'd1, 64'd1, 5'd10);
    tick;
    set_req(1, 1, 4'd0, 1'b1, 64'd2, 64'd2, 5'd11);
    bus.kill_1 = 1;
    at_mid;
    chk("E_ready_0", 64'(bus.req_ready_0), 64'd1);
    chk("E_ready_1", 64'(bus.req_ready_1), 64'd0);
    tick;
    bus.kill_1 = 0;
    at_mid;
    chk("E_next_ready_1", 64'(bus.req_ready_1), 64'd1);
    chk("E_next_ready_0", 64'(bus.req_ready_0), 64'd0);
    tick;

    // Reset with ops in flight
    reset_pulse;
    set_req(0, 1, 4'd0, 1'b1, 64'd5, 64'd5, 5'd20);
    tick;
    idle;
    set_req(1, 1, 4'd0, 1'b1, 64'd6, 64'd6, 5'd21);
    tick;
    idle;
    set_req(0, 1, 4'd0, 1'b1, 64'd7, 64'd7, 5'd22);
    tick;
    idle;
    reset = 1;
    at_mid;
    chk("F_busy_in_reset", 64'(bus.busy), 64'd0);
    chk("F_rv_in_reset", 64'(bus.resp_valid_0 | bus.resp_valid_1), 64'd0);
    tick;
    reset = 0;
    for (int j = 0; j < 4; j++) begin
      at_mid;
      chk("F_no_resp", 64'(bus.resp_valid_0 | bus.resp_valid_1), 64'd0);
      chk("F_busy", 64'(bus.busy), 64'd0);
      tick;
    end
    set_req(0, 1, 4'd0, 1'b1, 64'd1, 64'd1, 5'd23);
    set_req(1, 1, 4'd0, 1'b1, 64'd1, 64'd1, 5'd24);
    at_mid;
    chk("F_first_grant_0", 64'(bus.req_ready_0), 64'd1);
    chk("F_first_grant_1", 64'(bus.req_ready_1), 64'd0);
    tick;

    // Vector table
    reset_pulse;
    for (int r = 0; r < 12; r++) begin
      bus.req_valid_0 = tbl[r].v0; bus.req_tag_0 = 5'(r);
      bus.req_valid_1 = tbl[r].v1; bus.req_tag_1 = 5'(r + 16);
      bus.kill_0 = tbl[r].k0;      bus.kill_1 = tbl[r].k1;
      at_mid;
      chk("T_ready_0", 64'(bus.req_ready_0), 64'(tbl[r].r0));
      chk("T_ready_1", 64'(bus.req_ready_1), 64'(tbl[r].r1));
      chk("T_mul_valid", 64'(bus.mul_req_valid), 64'(tbl[r].r0 | tbl[r].r1));
      tick;
    end
    idle;
    repeat (LAT + 1) tick;

    // Randomized traffic against the reference model
    reset_pulse;
    for (int c = 0; c < 2000; c++) begin
      new0 = !bus.req_valid_0 || m_g0 || bus.kill_0;
      new1 = !bus.req_valid_1 || m_g1 || bus.kill_1;
      if (new0)
        set_req(0, $urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
      if (new1)
        set_req(1, $urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
      bus.kill_0 = ($urandom_range(0, 15) == 0);
      bus.kill_1 = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 79) == 0);
      tick;
    end
    reset = 0;
    idle;
    repeat (LAT + 2) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
